// File: rtl/fft_bfly_scheduler.sv
// -----------------------------------------------------------------------------
// fft_bfly_scheduler
//
// Sequences one radix-2 decimation stage of an in-place FFT. For every
// butterfly index k it reads the top and bottom samples from the sample RAM,
// fetches the matching twiddle, hands bottom*twiddle to an external complex
// multiplier, then writes back (X+Y)/2 to the top slot and (X-Y)/2 to the
// bottom slot. A multiplier that never answers is caught by a watchdog, which
// ends the stage with a sticky error.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle pulse, begins a stage (ignored while busy)
//   busy                  high from accepted start until done
//   done                  one-cycle pulse, stage finished or aborted
//   err                   sticky multiplier-timeout flag, cleared by next start
//   rd_en/rd_addr/rd_data sample RAM read port, data valid 1 cycle after rd_en
//   tw_addr/tw_data       twiddle ROM, data valid 1 cycle after the address
//   mul_en                one-cycle start pulse to the complex multiplier
//   mul_a..mul_d          operands: bottom.re, bottom.im, tw.re, tw.im
//   mul_rdy               multiplier result valid (level)
//   mul_real/mul_img      product, already scaled; low 12 bits are used
//   wr_en/wr_addr/wr_data sample RAM write port, data {re, im}
//
// All outputs are registered: each state's outputs are loaded on the clock
// edge that enters the state, so they are valid for the whole state cycle.
// -----------------------------------------------------------------------------
module fft_bfly_scheduler #(
  parameter int N_LOG2      = 4,
  parameter int STAGE       = 2,
  parameter int MUL_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr,
  input  logic [23:0]       rd_data,
  output logic [N_LOG2-2:0] tw_addr,
  input  logic [23:0]       tw_data,
  output logic              mul_en,
  output logic [11:0]       mul_a,
  output logic [11:0]       mul_b,
  output logic [11:0]       mul_c,
  output logic [11:0]       mul_d,
  input  logic              mul_rdy,
  input  logic [23:0]       mul_real,
  input  logic [23:0]       mul_img,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr,
  output logic [23:0]       wr_data
);

  localparam int AW       = N_LOG2;
  localparam int KW       = N_LOG2 - 1;
  localparam int TW_SHIFT = N_LOG2 - 1 - STAGE;
  localparam int WCW      = $clog2(MUL_TIMEOUT + 1);

  localparam logic [AW-1:0]  POS_MASK_A = AW'((1 << STAGE) - 1);
  localparam logic [AW-1:0]  SPAN_A     = AW'(1 << STAGE);
  localparam logic [KW-1:0]  POS_MASK_K = KW'((1 << STAGE) - 1);
  localparam logic [KW-1:0]  K_LAST     = KW'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [KW-1:0]  K_ONE      = KW'(1);
  localparam logic [KW-1:0]  K_ZERO     = KW'(0);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(MUL_TIMEOUT - 1);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(1);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_TOP = 4'd1,
    RD_BOT = 4'd2,
    CAP    = 4'd3,
    MUL    = 4'd4,
    WAIT   = 4'd5,
    WR_TOP = 4'd6,
    WR_BOT = 4'd7,
    FIN    = 4'd8
  } state_t;

  state_t         state_r;
  logic [KW-1:0]  k_r;
  logic [WCW-1:0] wait_cnt_r;
  logic [23:0]    x_r;   // top sample {re, im}
  logic [23:0]    y_r;   // scaled product {re, im}

  // Upper product bits are discarded: the multiplier already scales the
  // result so that the low 12 bits carry the value.
  logic unused_prod_bits_s;
  assign unused_prod_bits_s = ^{mul_real[23:12], mul_img[23:12]};

  // Top index: block number (k >> STAGE) times twice the span, plus the
  // position inside the block. Bit STAGE of the result is always zero.
  function automatic logic [AW-1:0] top_addr(input logic [KW-1:0] k);
    logic [AW-1:0] kk;
    kk = {1'b0, k};
    return ((kk >> STAGE) << (STAGE + 1)) | (kk & POS_MASK_A);
  endfunction

  // Bottom partner sits one span above the top; OR works because the
  // span bit of the top index is clear.
  function automatic logic [AW-1:0] bot_addr(input logic [KW-1:0] k);
    return top_addr(k) | SPAN_A;
  endfunction

  // Twiddle index: position in block scaled to the N/2-entry ROM.
  function automatic logic [KW-1:0] tw_index(input logic [KW-1:0] k);
    return (k & POS_MASK_K) << TW_SHIFT;
  endfunction

  // (a+b)>>>1 with a 13-bit intermediate; bits [12:1] are the shifted
  // result, which always fits 12 bits so nothing wraps.
  function automatic logic [11:0] half_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {a[11], a} + {b[11], b};
    return s[12:1];
  endfunction

  // (a-b)>>>1 with a 13-bit intermediate, same truncation as half_add.
  function automatic logic [11:0] half_sub(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {a[11], a} - {b[11], b};
    return s[12:1];
  endfunction

  // Stage sequencer: state, butterfly index, watchdog and all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      k_r        <= K_ZERO;
      wait_cnt_r <= '0;
      x_r        <= 24'd0;
      y_r        <= 24'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      tw_addr    <= '0;
      mul_en     <= 1'b0;
      mul_a      <= 12'd0;
      mul_b      <= 12'd0;
      mul_c      <= 12'd0;
      mul_d      <= 12'd0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= 24'd0;
    end else begin
      // Strobes are single-cycle unless the next state re-asserts them.
      rd_en  <= 1'b0;
      wr_en  <= 1'b0;
      mul_en <= 1'b0;
      done   <= 1'b0;

      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RD_TOP;
            k_r     <= K_ZERO;
            err     <= 1'b0;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= top_addr(K_ZERO);
            tw_addr <= tw_index(K_ZERO);
          end
        end

        RD_TOP: begin
          state_r <= RD_BOT;
          rd_en   <= 1'b1;
          rd_addr <= bot_addr(k_r);
        end

        // Read data for the top address arrives during this cycle.
        RD_BOT: begin
          state_r <= CAP;
          x_r     <= rd_data;
        end

        // Bottom sample and twiddle are both valid now; they go straight
        // into the operand registers, which hold until WAIT is left.
        CAP: begin
          state_r <= MUL;
          mul_en  <= 1'b1;
          mul_a   <= rd_data[23:12];
          mul_b   <= rd_data[11:0];
          mul_c   <= tw_data[23:12];
          mul_d   <= tw_data[11:0];
        end

        // mul_rdy is deliberately not looked at here: a level left over
        // from a previous product must not be taken as this result.
        MUL: begin
          state_r    <= WAIT;
          wait_cnt_r <= '0;
        end

        WAIT: begin
          if (mul_rdy) begin
            state_r <= WR_TOP;
            y_r     <= {mul_real[11:0], mul_img[11:0]};
            wr_en   <= 1'b1;
            wr_addr <= top_addr(k_r);
            wr_data <= {half_add(x_r[23:12], mul_real[11:0]),
                        half_add(x_r[11:0],  mul_img[11:0])};
          end else if (wait_cnt_r == WAIT_LAST) begin
            // Watchdog expired: abandon the stage without writing.
            state_r <= FIN;
            err     <= 1'b1;
            done    <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end

        WR_TOP: begin
          state_r <= WR_BOT;
          wr_en   <= 1'b1;
          wr_addr <= bot_addr(k_r);
          wr_data <= {half_sub(x_r[23:12], y_r[23:12]),
                      half_sub(x_r[11:0],  y_r[11:0])};
        end

        WR_BOT: begin
          if (k_r == K_LAST) begin
            state_r <= FIN;
            done    <= 1'b1;
          end else begin
            state_r <= RD_TOP;
            k_r     <= k_r + K_ONE;
            rd_en   <= 1'b1;
            rd_addr <= top_addr(k_r + K_ONE);
            tw_addr <= tw_index(k_r + K_ONE);
          end
        end

        // done is high in this cycle; busy drops as IDLE is entered.
        FIN: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bfly_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fft_bfly_scheduler
//
// Directed bench for fft_bfly_scheduler (N_LOG2=4, STAGE=2, MUL_TIMEOUT=64).
// Behavioural sample RAM, twiddle ROM and a 3-cycle complex multiplier
// respond to the DUT. An independent butterfly model builds the expected
// write and operand sequences; hand-computed vectors cover the arithmetic
// corners, the watchdog, stale mul_rdy, start-while-busy and mid-stage reset.
// -----------------------------------------------------------------------------
module tb_fft_bfly_scheduler;

  localparam int N_LOG2      = 4;
  localparam int STAGE       = 2;
  localparam int MUL_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, err;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [23:0] rd_data;
  logic [2:0]  tw_addr;
  logic [23:0] tw_data;
  logic        mul_en;
  logic [11:0] mul_a, mul_b, mul_c, mul_d;
  logic        mul_rdy;
  logic [23:0] mul_real, mul_img;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;

  fft_bfly_scheduler #(
    .N_LOG2(N_LOG2), .STAGE(STAGE), .MUL_TIMEOUT(MUL_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tw_addr(tw_addr), .tw_data(tw_data),
    .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
    .mul_rdy(mul_rdy), .mul_real(mul_real), .mul_img(mul_img),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- environment models ----------------
  logic [23:0] mem [16];
  logic [23:0] rom [8];

  int          mul_mode = 0;      // 0 normal, 1 never ready, 2 stale rdy in MUL cycle
  logic        force_y  = 1'b0;
  logic [11:0] fy_re    = 12'd0;
  logic [11:0] fy_im    = 12'd0;
  int          mul_cnt  = 0;
  logic        mul_rdy_r = 1'b0;
  logic [23:0] mul_real_r = 24'd0;
  logic [23:0] mul_img_r  = 24'd0;

  function automatic logic [23:0] cmul_re(input logic [11:0] a, b, c, d);
    int ia, ib, ic, iq, r;
    ia = int'($signed(a)); ib = int'($signed(b));
    ic = int'($signed(c)); iq = int'($signed(d));
    r  = (ia * ic - ib * iq) >>> 7;
    return r[23:0];
  endfunction

  function automatic logic [23:0] cmul_im(input logic [11:0] a, b, c, d);
    int ia, ib, ic, iq, r;
    ia = int'($signed(a)); ib = int'($signed(b));
    ic = int'($signed(c)); iq = int'($signed(d));
    r  = (ia * iq + ib * ic) >>> 7;
    return r[23:0];
  endfunction

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];
  always @(posedge clk) tw_data <= rom[tw_addr];

  always @(posedge clk) begin
    mul_rdy_r <= 1'b0;
    if (mul_en) begin
      mul_cnt <= 1;
    end else if (mul_cnt == 2) begin
      mul_cnt <= 0;
      if (mul_mode != 1) begin
        mul_rdy_r  <= 1'b1;
        mul_real_r <= force_y ? {{12{fy_re[11]}}, fy_re} : cmul_re(mul_a, mul_b, mul_c, mul_d);
        mul_img_r  <= force_y ? {{12{fy_im[11]}}, fy_im} : cmul_im(mul_a, mul_b, mul_c, mul_d);
      end
    end else if (mul_cnt != 0) begin
      mul_cnt <= mul_cnt + 1;
    end
  end

  // Stale mode shows a bogus ready with garbage data during the MUL cycle.
  assign mul_rdy  = mul_rdy_r | ((mul_mode == 2) && mul_en);
  assign mul_real = ((mul_mode == 2) && mul_en) ? 24'hABCABC : mul_real_r;
  assign mul_img  = ((mul_mode == 2) && mul_en) ? 24'h5A55A5 : mul_img_r;

  // ---------------- monitor ----------------
  logic [3:0]  got_addr[$];
  logic [23:0] got_data[$];
  logic [47:0] got_ops[$];
  logic [2:0]  got_tw[$];
  int          done_cnt = 0;
  int          overlap  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        got_addr.push_back(wr_addr);
        got_data.push_back(wr_data);
      end
      if (mul_en) begin
        got_ops.push_back({mul_a, mul_b, mul_c, mul_d});
        got_tw.push_back(tw_addr);
      end
      if (done) done_cnt++;
      if ((int'(rd_en) + int'(wr_en) + int'(mul_en)) > 1) overlap++;
    end
  end

  // ---------------- expected model ----------------
  logic [3:0]  exp_addr[$];
  logic [23:0] exp_data[$];
  logic [47:0] exp_ops[$];
  logic [2:0]  exp_tw[$];

  function automatic int sx12(input logic [11:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [11:0] bfly(input int x, input int y, input bit sub);
    int t;
    t = sub ? (x - y) : (x + y);
    t = t >>> 1;
    return t[11:0];
  endfunction

  task automatic build_expected();
    exp_addr.delete(); exp_data.delete(); exp_ops.delete(); exp_tw.delete();
    for (int k = 0; k < 8; k++) begin
      int span, pos, top, bot, tw, xr, xi, yr, yi;
      logic [23:0] xv, bv, wv, yre, yim;
      span = 1 << STAGE;
      pos  = k % span;
      top  = (k / span) * 2 * span + pos;
      bot  = top + span;
      tw   = pos * (8 / span);
      xv = mem[top]; bv = mem[bot]; wv = rom[tw];
      if (force_y) begin
        yre = {12'd0, fy_re};
        yim = {12'd0, fy_im};
      end else begin
        yre = cmul_re(bv[23:12], bv[11:0], wv[23:12], wv[11:0]);
        yim = cmul_im(bv[23:12], bv[11:0], wv[23:12], wv[11:0]);
      end
      exp_ops.push_back({bv, wv});
      exp_tw.push_back(tw[2:0]);
      xr = sx12(xv[23:12]); xi = sx12(xv[11:0]);
      yr = sx12(yre[11:0]); yi = sx12(yim[11:0]);
      exp_addr.push_back(top[3:0]);
      exp_data.push_back({bfly(xr, yr, 1'b0), bfly(xi, yi, 1'b0)});
      exp_addr.push_back(bot[3:0]);
      exp_data.push_back({bfly(xr, yr, 1'b1), bfly(xi, yi, 1'b1)});
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    got_addr.delete(); got_data.delete(); got_ops.delete(); got_tw.delete();
    done_cnt = 0;
    overlap  = 0;
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_nwr"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      check($sformatf("%s_wa%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
      check($sformatf("%s_wd%0d", tag, i), 64'(got_data[i]), 64'(exp_data[i]));
    end
    check({tag, "_nops"}, 64'(got_ops.size()), 64'(exp_ops.size()));
    for (int i = 0; i < got_ops.size() && i < exp_ops.size(); i++) begin
      check($sformatf("%s_op%0d", tag, i), 64'(got_ops[i]), 64'(exp_ops[i]));
      check($sformatf("%s_tw%0d", tag, i), 64'(got_tw[i]), 64'(exp_tw[i]));
    end
    check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, "_overlap"}, 64'(overlap), 64'd0);
  endtask

  // Pulse start, optionally poke start again while busy, wait for done.
  task automatic run_stage(input string tag, input int budget, input int poke,
                           output int cyc, output logic err_start, output logic err_done);
    clear_logs();
    build_expected();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;
    err_start = err;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke);
    end
    start = 1'b0;
    err_done = err;
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   cyc, n;
    logic es, ed;

    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
    for (int i = 0; i < 8; i++)  rom[i] = 24'($urandom);

    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({busy, done, err, rd_en, wr_en, mul_en}), 64'd0);
    check("rst_addr", 64'({rd_addr, tw_addr, wr_addr}), 64'd0);
    check("rst_wdata", 64'(wr_data), 64'd0);
    check("rst_ops", 64'({mul_a, mul_b, mul_c, mul_d}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal stage: 8 butterflies, 9 cycles each, done in cycle 73.
    run_stage("norm", 200, -1, cyc, es, ed);
    check("norm_cycles", 64'(cyc), 64'd73);
    check("norm_err", 64'(ed), 64'd0);
    compare_logs("norm");
    check("norm_tw1", 64'(got_tw[1]), 64'd2);
    check("norm_tw3", 64'(got_tw[3]), 64'd6);
    check("norm_tw4", 64'(got_tw[4]), 64'd0);
    check("norm_a8", 64'(got_addr[8]), 64'd8);
    check("norm_a9", 64'(got_addr[9]), 64'd12);
    check("norm_a14", 64'(got_addr[14]), 64'd11);
    check("norm_a15", 64'(got_addr[15]), 64'd15);
    check("norm_idle_busy", 64'(busy), 64'd0);

    // start while busy is ignored.
    run_stage("poke", 200, 20, cyc, es, ed);
    check("poke_cycles", 64'(cyc), 64'd73);
    compare_logs("poke");

    // X=(400,-200), Y=(100,50) -> top (250,-75), bot (150,-125).
    force_y = 1'b1; fy_re = 12'd100; fy_im = 12'd50;
    mem[0] = 24'h190F38;
    run_stage("v26", 200, -1, cyc, es, ed);
    check("v26_a0", 64'(got_addr[0]), 64'd0);
    check("v26_top", 64'(got_data[0]), 64'h0FAFB5);
    check("v26_a1", 64'(got_addr[1]), 64'd4);
    check("v26_bot", 64'(got_data[1]), 64'h096F83);
    compare_logs("v26");

    // Largest positive operands: top (2047,2047), bot (0,0).
    fy_re = 12'h7FF; fy_im = 12'h7FF;
    mem[0] = 24'h7FF7FF;
    run_stage("vmax", 200, -1, cyc, es, ed);
    check("vmax_top", 64'(got_data[0]), 64'h7FF7FF);
    check("vmax_bot", 64'(got_data[1]), 64'h000000);

    // X=(-2048,0), Y=(2047,0): top (-1,0), bot (-2048,0) without wrap.
    fy_re = 12'h7FF; fy_im = 12'h000;
    mem[0] = 24'h800000;
    run_stage("vmin", 200, -1, cyc, es, ed);
    check("vmin_top", 64'(got_data[0]), 64'hFFF000);
    check("vmin_bot", 64'(got_data[1]), 64'h800000);
    compare_logs("vmin");
    force_y = 1'b0;

    // Multiplier never answers: done in cycle 4 + 64 + 1, err set, no writes.
    mul_mode = 1;
    run_stage("tmo", 200, -1, cyc, es, ed);
    check("tmo_cycles", 64'(cyc), 64'(4 + MUL_TIMEOUT + 1));
    check("tmo_err", 64'(ed), 64'd1);
    check("tmo_nwr", 64'(got_addr.size()), 64'd0);
    check("tmo_nops", 64'(got_ops.size()), 64'd1);
    check("tmo_done_cnt", 64'(done_cnt), 64'd1);
    check("tmo_err_sticky", 64'({err, busy}), 64'b10);
    mul_mode = 0;

    // Next start clears err.
    run_stage("clr", 200, -1, cyc, es, ed);
    check("clr_err_start", 64'(es), 64'd0);
    check("clr_err_done", 64'(ed), 64'd0);
    compare_logs("clr");

    // Stale ready in the MUL cycle must not be taken.
    mul_mode = 2;
    run_stage("stale", 200, -1, cyc, es, ed);
    check("stale_cycles", 64'(cyc), 64'd73);
    compare_logs("stale");
    mul_mode = 0;

    // Reset in the WAIT state of k=3.
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mul_en) n++;
    end
    check("mid_k3_reached", 64'(n), 64'd4);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_ctrl", 64'({busy, done, err, rd_en, wr_en, mul_en}), 64'd0);
    check("mid_addr", 64'({rd_addr, tw_addr, wr_addr}), 64'd0);
    check("mid_data", 64'({wr_data, mul_a, mul_b, mul_c, mul_d}), 64'd0);
    repeat (3) @(negedge clk);
    check("mid_nwr", 64'(got_addr.size()), 64'd6);
    check("mid_no_done", 64'(done_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_stage("after", 200, -1, cyc, es, ed);
    check("after_cycles", 64'(cyc), 64'd73);
    compare_logs("after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
